// File: rtl/aes_mode_ctrl.sv
// Block-cipher mode controller: sequences ECB/CBC/CTR messages through a
// single-block cipher core with valid/ready streaming on input and output.
module aes_mode_ctrl #(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned KEY_W   = 128,
  parameter int unsigned CTR_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic               encdec_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic [BLOCK_W-1:0] iv_i,
  input  logic               din_valid_i,
  output logic               din_ready_o,
  input  logic [BLOCK_W-1:0] din_data_i,
  input  logic               din_last_i,
  output logic               dout_valid_o,
  input  logic               dout_ready_i,
  output logic [BLOCK_W-1:0] dout_data_o,
  output logic               dout_last_o,
  output logic               core_on_o,
  output logic               core_encdec_o,
  output logic [KEY_W-1:0]   core_key_o,
  output logic [BLOCK_W-1:0] core_block_o,
  input  logic               core_ready_i,
  input  logic [BLOCK_W-1:0] core_result_i,
  input  logic               core_result_valid_i,
  output logic               busy_o,
  output logic               err_o
);

  localparam logic [1:0] MODE_ECB = 2'd0;
  localparam logic [1:0] MODE_CBC = 2'd1;
  localparam logic [1:0] MODE_CTR = 2'd2;
  localparam logic [1:0] MODE_BAD = 2'd3;

  // Only the low CTR_W bits of the counter block increment; upper bits are fixed.
  localparam logic [BLOCK_W-1:0] CTR_MASK = {BLOCK_W{1'b1}} >> (BLOCK_W - CTR_W);

  typedef enum logic [2:0] {IDLE, WAIT_IN, ISSUE, WAIT_CORE, OUT} state_e;

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic                 core_encdec_q, core_encdec_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [BLOCK_W-1:0]   chain_q, chain_d;
  logic [BLOCK_W-1:0]   ctr_q, ctr_d;
  logic [BLOCK_W-1:0]   din_q, din_d;
  logic                 last_q, last_d;
  logic [BLOCK_W-1:0]   core_block_q, core_block_d;
  logic                 core_on_q, core_on_d;
  logic [BLOCK_W-1:0]   dout_data_q, dout_data_d;
  logic                 dout_last_q, dout_last_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 din_ready_q, din_ready_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  // Next-state and datapath decode.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    core_encdec_d = core_encdec_q;
    key_d         = key_q;
    chain_d       = chain_q;
    ctr_d         = ctr_q;
    din_d         = din_q;
    last_d        = last_q;
    core_block_d  = core_block_q;
    core_on_d     = 1'b0;
    dout_data_d   = dout_data_q;
    dout_last_d   = dout_last_q;
    err_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (mode_i == MODE_BAD) begin
            err_d = 1'b1;
          end else begin
            mode_d        = mode_i;
            core_encdec_d = (mode_i == MODE_CTR) ? 1'b1 : encdec_i;
            key_d         = key_i;
            chain_d       = iv_i;
            ctr_d         = iv_i;
            state_d       = WAIT_IN;
          end
        end
      end
      WAIT_IN: begin
        if (din_valid_i) begin
          din_d  = din_data_i;
          last_d = din_last_i;
          case (mode_q)
            MODE_CBC: core_block_d = core_encdec_q ? (din_data_i ^ chain_q) : din_data_i;
            MODE_CTR: core_block_d = ctr_q;
            default:  core_block_d = din_data_i;
          endcase
          // Start pulse is registered, so it lands in the first ISSUE cycle.
          core_on_d = core_ready_i;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (core_on_q) begin
          state_d = WAIT_CORE;
        end else begin
          core_on_d = core_ready_i;
        end
      end
      WAIT_CORE: begin
        if (core_result_valid_i) begin
          case (mode_q)
            MODE_CBC: dout_data_d = core_encdec_q ? core_result_i : (core_result_i ^ chain_q);
            MODE_CTR: dout_data_d = din_q ^ core_result_i;
            default:  dout_data_d = core_result_i;
          endcase
          dout_last_d = last_q;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (dout_ready_i) begin
          if (mode_q == MODE_CBC) begin
            chain_d = core_encdec_q ? dout_data_q : din_q;
          end
          if (mode_q == MODE_CTR) begin
            ctr_d = (ctr_q & ~CTR_MASK) | ((ctr_q + BLOCK_W'(1)) & CTR_MASK);
          end
          state_d = last_q ? IDLE : WAIT_IN;
        end
      end
      default: state_d = IDLE;
    endcase

    din_ready_d  = (state_d == WAIT_IN);
    dout_valid_d = (state_d == OUT);
    busy_d       = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      mode_q        <= MODE_ECB;
      core_encdec_q <= 1'b0;
      key_q         <= '0;
      chain_q       <= '0;
      ctr_q         <= '0;
      din_q         <= '0;
      last_q        <= 1'b0;
      core_block_q  <= '0;
      core_on_q     <= 1'b0;
      dout_data_q   <= '0;
      dout_last_q   <= 1'b0;
      dout_valid_q  <= 1'b0;
      din_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      core_encdec_q <= core_encdec_d;
      key_q         <= key_d;
      chain_q       <= chain_d;
      ctr_q         <= ctr_d;
      din_q         <= din_d;
      last_q        <= last_d;
      core_block_q  <= core_block_d;
      core_on_q     <= core_on_d;
      dout_data_q   <= dout_data_d;
      dout_last_q   <= dout_last_d;
      dout_valid_q  <= dout_valid_d;
      din_ready_q   <= din_ready_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign din_ready_o   = din_ready_q;
  assign dout_valid_o  = dout_valid_q;
  assign dout_data_o   = dout_data_q;
  assign dout_last_o   = dout_last_q;
  assign core_on_o     = core_on_q;
  assign core_encdec_o = core_encdec_q;
  assign core_key_o    = key_q;
  assign core_block_o  = core_block_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl with an XOR-with-key core stub
// answering five cycles after each start pulse.
module tb_aes_mode_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [1:0]   mode_i = 2'd0;
  logic         encdec_i = 1'b0;
  logic [127:0] key_i = '0;
  logic [127:0] iv_i = '0;
  logic         din_valid_i = 1'b0;
  logic         din_ready_o;
  logic [127:0] din_data_i = '0;
  logic         din_last_i = 1'b0;
  logic         dout_valid_o;
  logic         dout_ready_i = 1'b0;
  logic [127:0] dout_data_o;
  logic         dout_last_o;
  logic         core_on_o;
  logic         core_encdec_o;
  logic [127:0] core_key_o;
  logic [127:0] core_block_o;
  logic         core_ready_i;
  logic [127:0] core_result_i = '0;
  logic         core_result_valid_i = 1'b0;
  logic         busy_o;
  logic         err_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [2:0]  stub_cnt = '0;

  always #5 clk_i = ~clk_i;

  aes_mode_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .encdec_i(encdec_i), .key_i(key_i), .iv_i(iv_i),
    .din_valid_i(din_valid_i), .din_ready_o(din_ready_o),
    .din_data_i(din_data_i), .din_last_i(din_last_i),
    .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
    .dout_data_o(dout_data_o), .dout_last_o(dout_last_o),
    .core_on_o(core_on_o), .core_encdec_o(core_encdec_o),
    .core_key_o(core_key_o), .core_block_o(core_block_o),
    .core_ready_i(core_ready_i), .core_result_i(core_result_i),
    .core_result_valid_i(core_result_valid_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  // Core stub: result = block ^ key, one-cycle valid five cycles after start.
  assign core_ready_i = (stub_cnt == 3'd0);
  always @(posedge clk_i) begin
    core_result_valid_i <= 1'b0;
    if (core_on_o) begin
      stub_cnt      <= 3'd5;
      core_result_i <= core_block_o ^ core_key_o;
    end else if (stub_cnt != 3'd0) begin
      stub_cnt <= stub_cnt - 3'd1;
      if (stub_cnt == 3'd1) core_result_valid_i <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_msg(input logic [1:0] mode, input logic enc,
                           input logic [127:0] key, input logic [127:0] iv);
    mode_i = mode; encdec_i = enc; key_i = key; iv_i = iv; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Offer one block; checks the start pulse one cycle after acceptance.
  task automatic send_block(input string tag, input logic [127:0] data, input logic last,
                            input logic [127:0] exp_block);
    int budget = 50;
    din_data_i = data; din_last_i = last; din_valid_i = 1'b1;
    while (!din_ready_o && budget > 0) begin tick(); budget--; end
    if (budget == 0) check({tag, "_din_timeout"}, 128'd0, 128'd1);
    tick();
    din_valid_i = 1'b0;
    check({tag, "_core_on"}, 128'(core_on_o), 128'd1);
    check({tag, "_core_block"}, core_block_o, exp_block);
  endtask

  // Wait for an output, check latency and payload, then handshake it.
  task automatic recv_block(input string tag, input logic [127:0] exp, input logic exp_last,
                            input int stall);
    int   budget = 50;
    logic prev_rv = 1'b0;
    while (!dout_valid_o && budget > 0) begin prev_rv = core_result_valid_i; tick(); budget--; end
    if (budget == 0) begin
      check({tag, "_dout_timeout"}, 128'd0, 128'd1);
    end else begin
      check({tag, "_latency"}, 128'(prev_rv), 128'd1);
      check({tag, "_dout"}, dout_data_o, exp);
      check({tag, "_last"}, 128'(dout_last_o), 128'(exp_last));
      for (int i = 0; i < stall; i++) begin
        tick();
        check({tag, "_stall_valid"}, 128'(dout_valid_o), 128'd1);
        check({tag, "_stall_data"}, dout_data_o, exp);
        check({tag, "_stall_din_ready"}, 128'(din_ready_o), 128'd0);
      end
      dout_ready_i = 1'b1;
      tick();
      dout_ready_i = 1'b0;
    end
  endtask

  initial begin
    bit seen_dout;
    tick(); tick();
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_din_ready", 128'(din_ready_o), 128'd0);
    check("rst_dout_valid", 128'(dout_valid_o), 128'd0);
    check("rst_core_on", 128'(core_on_o), 128'd0);
    check("rst_err", 128'(err_o), 128'd0);
    check("rst_core_block", core_block_o, 128'd0);
    rst_i = 1'b0;
    tick();

    // ECB encrypt, single block
    start_msg(2'd0, 1'b1, 128'h1, 128'h0);
    check("ecb_busy", 128'(busy_o), 128'd1);
    send_block("ecb", 128'h3, 1'b1, 128'h3);
    check("ecb_encdec", 128'(core_encdec_o), 128'd1);
    recv_block("ecb", 128'h2, 1'b1, 0);
    check("ecb_idle_busy", 128'(busy_o), 128'd0);
    check("ecb_idle_din_ready", 128'(din_ready_o), 128'd0);

    // CBC encrypt, two blocks
    start_msg(2'd1, 1'b1, 128'h1, 128'h10);
    send_block("cbce0", 128'h3, 1'b0, 128'h13);
    recv_block("cbce0", 128'h12, 1'b0, 0);
    send_block("cbce1", 128'h5, 1'b1, 128'h17);
    recv_block("cbce1", 128'h16, 1'b1, 0);

    // CBC decrypt, two blocks
    start_msg(2'd1, 1'b0, 128'h1, 128'h10);
    send_block("cbcd0", 128'h12, 1'b0, 128'h12);
    check("cbcd_encdec", 128'(core_encdec_o), 128'd0);
    recv_block("cbcd0", 128'h3, 1'b0, 0);
    send_block("cbcd1", 128'h16, 1'b1, 128'h16);
    recv_block("cbcd1", 128'h5, 1'b1, 0);

    // CTR with counter wrap in the low 32 bits; encdec_i low still encrypts
    start_msg(2'd2, 1'b0, 128'h0, 128'hAB_FFFFFFFF);
    send_block("ctr0", 128'h0, 1'b0, 128'hAB_FFFFFFFF);
    check("ctr_encdec", 128'(core_encdec_o), 128'd1);
    recv_block("ctr0", 128'hAB_FFFFFFFF, 1'b0, 0);
    send_block("ctr1", 128'h0, 1'b1, 128'hAB_00000000);
    recv_block("ctr1", 128'hAB_00000000, 1'b1, 0);

    // Output back-pressure held for 10 cycles
    start_msg(2'd0, 1'b1, 128'h1, 128'h0);
    send_block("stall", 128'h7, 1'b1, 128'h7);
    recv_block("stall", 128'h6, 1'b1, 10);

    // Illegal mode
    start_msg(2'd3, 1'b1, 128'h1, 128'h0);
    check("err_pulse", 128'(err_o), 128'd1);
    check("err_busy", 128'(busy_o), 128'd0);
    tick();
    check("err_one_cycle", 128'(err_o), 128'd0);
    check("err_busy_after", 128'(busy_o), 128'd0);
    check("err_din_ready", 128'(din_ready_o), 128'd0);

    // Reset while waiting on the core; the late result must be ignored
    start_msg(2'd0, 1'b1, 128'h1, 128'h0);
    send_block("rstmid", 128'h9, 1'b1, 128'h9);
    tick(); tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    seen_dout = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dout_valid_o) seen_dout = 1'b1;
    end
    check("rstmid_no_dout", 128'(seen_dout), 128'd0);
    check("rstmid_busy", 128'(busy_o), 128'd0);
    check("rstmid_dout_data", dout_data_o, 128'd0);
    check("rstmid_core_block", core_block_o, 128'd0);
    check("rstmid_din_ready", 128'(din_ready_o), 128'd0);
    check("rstmid_dout_last", 128'(dout_last_o), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_mode_ctrl.md
AES_MODE_CTRL -- requirements
Module: aes_mode_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- BLOCK_W, 128, data block and IV width.
- KEY_W, 128, key width.
- CTR_W, 32, width of the incrementing counter field (IV bits [CTR_W-1:0]); 1 <= CTR_W <= BLOCK_W.
REQ-002 There SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  begin message; latches mode_i, encdec_i, key_i, iv_i.
- mode_i  in  2  0=ECB, 1=CBC, 2=CTR, 3=illegal.
- encdec_i  in  1  1=encrypt, 0=decrypt.
- key_i  in  KEY_W  key.
- iv_i  in  BLOCK_W  IV or initial counter block.
- din_valid_i / din_ready_o  in / out  1  input handshake.
- din_data_i  in  BLOCK_W  input block.
- din_last_i  in  1  final block of message.
- dout_valid_o / dout_ready_i  out / in  1  output handshake.
- dout_data_o  out  BLOCK_W  output block.
- dout_last_o  out  1  final output block.
- core_on_o  out  1  one-cycle start pulse to the cipher core (key init followed by block).
- core_encdec_o  out  1  direction to the core.
- core_key_o  out  KEY_W  latched key.
- core_block_o  out  BLOCK_W  core input block.
- core_ready_i  in  1  core idle.
- core_result_i  in  BLOCK_W  core output.
- core_result_valid_i  in  1  one-cycle result pulse.
- busy_o  out  1  message in progress.
- err_o  out  1  one-cycle illegal-mode pulse.

Function
REQ-004 FSM states SHALL be IDLE, WAIT_IN, ISSUE, WAIT_CORE, OUT.
REQ-005 IDLE transitions:
- start_i with mode 0-2: latch config, chain <= iv_i, ctr <= iv_i, go to WAIT_IN next cycle.
- start_i with mode 3: pulse err_o for one cycle and stay in IDLE.
REQ-006 WAIT_IN SHALL drive din_ready_o=1. On din_valid_i, it SHALL latch din_data_i/din_last_i and go to ISSUE. din_ready_o SHALL be 0 in every other state.
REQ-007 ISSUE SHALL pulse core_on_o for exactly one cycle when core_ready_i=1 (otherwise wait), then go to WAIT_CORE. core_block_o SHALL hold stable from ISSUE until result.
REQ-008 WAIT_CORE SHALL capture core_result_i on core_result_valid_i, form the output, and go to OUT. core_result_valid_i in any other state SHALL be ignored.
REQ-009 OUT SHALL assert dout_valid_o with dout_data_o/dout_last_o stable until dout_ready_i. On handshake it SHALL go to IDLE if last, otherwise WAIT_IN.
REQ-010 ECB: core_block = din; out = result; core_encdec_o = encdec.
REQ-011 CBC encrypt: core_block = din XOR chain; out = result; chain <= result.
REQ-012 CBC decrypt: core_block = din; out = result XOR chain; chain <= din.
REQ-013 CTR: core_block = ctr; core_encdec_o = 1 regardless of encdec; out = din XOR result. After each block, ctr[CTR_W-1:0] <= +1 mod 2^CTR_W, with upper bits unchanged (wrap, no carry out).
REQ-014 Chain/ctr SHALL update only on the output handshake.
REQ-015 busy_o SHALL be 1 in every state except IDLE.
REQ-016 start_i outside IDLE SHALL be ignored.
REQ-017 start_i and din_valid_i in the same IDLE cycle: the block SHALL NOT be accepted.
REQ-018 Timing SHALL be fixed:
- din accept cycle t -> core_on_o at t+1 (given core_ready_i).
- core_result_valid_i at cycle r -> dout_valid_o at r+1.

Reset
REQ-019 Reset SHALL force, at the next edge regardless of state:
- state IDLE;
- din_ready_o, dout_valid_o, dout_last_o, core_on_o, busy_o, err_o = 0;
- dout_data_o, core_block_o, chain, ctr = 0.
REQ-020 A core_result_valid_i arriving after a reset mid-operation SHALL be ignored.

Verification (bench core stub: result = block XOR key[BLOCK_W-1:0], 5 cycles after core_on_o; defaults)
REQ-021 ECB encrypt, key=0x1, din=0x3, last=1 -> dout 0x2, dout_last_o=1, then IDLE and busy_o=0.
REQ-022 CBC encrypt, key=0x1, iv=0x10, din 0x3 then 0x5 -> core_block_o 0x13 then 0x17; dout 0x12 then 0x16.
REQ-023 CBC decrypt, same key/iv, din 0x12 then 0x16 -> dout 0x3 then 0x5.
REQ-024 CTR, key=0, iv = 0xAB_FFFFFFFF, din=0 twice -> dout 0xAB_FFFFFFFF then 0xAB_00000000 (counter wraps, upper bits unchanged).
REQ-025 dout_ready_i held low 10 cycles -> dout_valid_o=1 with data stable throughout, and din_ready_o=0.
REQ-026 Error and reset cases:
- mode_i=3 with start_i -> err_o high exactly 1 cycle, busy_o stays 0.
- rst_i asserted in WAIT_CORE, then a late core_result_valid_i -> all outputs at reset values and no dout_valid_o.
